// File: rtl/up_dn_cmd_scheduler.sv
// Command front-end for a WIDTH-bit up/down counter: round-robin arbitration of two
// requesters, then LOAD / UP-by-N / DOWN-by-N / NOP executed as single-cycle strobes.
module up_dn_cmd_scheduler #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_arg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_arg,
  output logic             req1_ready,
  input  logic             ctr_high,
  input  logic             ctr_low,
  output logic [WIDTH-1:0] ctr_in,
  output logic             ctr_load,
  output logic             ctr_up,
  output logic             ctr_down,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             done_sat,
  output logic [WIDTH-1:0] done_steps
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;

  state_t           state, state_d;
  logic             last_grant;
  logic             gnt_vld, gnt_id, accept;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_arg;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic             id_q;
  logic [WIDTH-1:0] steps, steps_d;
  logic [WIDTH-1:0] remaining, remaining_d;
  logic             sat, sat_d;
  logic             boundary, step_go;

  // When both request, the one that did not win last time gets the grant.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = 1'b0;
    if (req0_valid && req1_valid)
      gnt_id = ~last_grant;
    else if (req1_valid)
      gnt_id = 1'b1;
    accept  = (state == S_IDLE) && gnt_vld;
    sel_op  = gnt_id ? req1_op  : req0_op;
    sel_arg = gnt_id ? req1_arg : req0_arg;
  end

  // The boundary flag gates the strobe combinationally, so the counter never wraps.
  always_comb begin
    boundary = (op_q == OP_UP) ? ctr_high : ctr_low;
    step_go  = (state == S_STEP) && !boundary;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (sel_op)
            OP_LOAD:        state_d = S_LOAD;
            OP_UP, OP_DOWN: state_d = (sel_arg != '0) ? S_STEP : S_DONE;
            default:        state_d = S_DONE;
          endcase
        end
      end
      S_LOAD: state_d = S_DONE;
      S_STEP: begin
        if (boundary || remaining == WIDTH'(1))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !gnt_id;
    req1_ready = accept &&  gnt_id;
    ctr_load   = (state == S_LOAD);
    ctr_in     = (state == S_LOAD) ? arg_q : '0;
    ctr_up     = step_go && (op_q == OP_UP);
    ctr_down   = step_go && (op_q == OP_DOWN);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

  // Next values of the step bookkeeping, shared by the live registers and the done capture.
  always_comb begin
    steps_d     = steps;
    remaining_d = remaining;
    sat_d       = sat;
    if (accept) begin
      steps_d     = '0;
      remaining_d = (state_d == S_STEP) ? sel_arg : '0;
      sat_d       = 1'b0;
    end else if (step_go) begin
      steps_d     = steps + WIDTH'(1);
      remaining_d = remaining - WIDTH'(1);
    end else if (state == S_STEP) begin
      sat_d       = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      steps      <= '0;
      remaining  <= '0;
      sat        <= 1'b0;
      done_id    <= 1'b0;
      done_sat   <= 1'b0;
      done_steps <= '0;
    end else begin
      steps     <= steps_d;
      remaining <= remaining_d;
      sat       <= sat_d;
      if (accept)
        last_grant <= gnt_id;
      if (state_d == S_DONE && state != S_DONE) begin
        done_id    <= accept ? gnt_id : id_q;
        done_sat   <= sat_d;
        done_steps <= steps_d;
      end
    end
  end

  // Command payload; only meaningful after an accept, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q  <= sel_op;
      arg_q <= sel_arg;
      id_q  <= gnt_id;
    end
  end

endmodule
